// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: folded CORDIC core, one micro-rotation per cycle, rotation or vectoring per transaction.
// Optional `CORDIC_GAIN_COMP_EN adds a single gain-compensation cycle so x_out/y_out come out at unit gain.
module cordic_iter_engine #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int ITER = 14,
  localparam int W = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_mode,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out
);
  localparam int SH = 30 - DEC_WIDTH;
  localparam logic [32:0] RND_A = (33'd1 << SH) >> 1;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  // atan(2^-i) with 30 fraction bits, scaled down to DEC_WIDTH at lookup
  localparam logic [31:0] ATAN30 [16] = '{
    32'd843314857, 32'd497837830, 32'd263043837, 32'd133525159,
    32'd67021687,  32'd33543516,  32'd16775851,  32'd8388438,
    32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
    32'd262144,    32'd131072,    32'd65536,     32'd32768};
  typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [32:0] at;
  logic signed [W-1:0] a, sx, sy, nx, ny, nz;
  logic d;
  always_comb begin
    at = ({1'b0, ATAN30[cnt]} + RND_A) >> SH;
    a = W'(at);
    sx = x_out >>> cnt;
    sy = y_out >>> cnt;
    d = out_mode ? y_out[W-1] : ~z_out[W-1];
    nx = d ? x_out - sy : x_out + sy;
    ny = d ? y_out + sx : y_out - sx;
    nz = d ? z_out - a : z_out + a;
  end
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [W-1:0] CK = W'(int'(0.607253 * (2.0 ** DEC_WIDTH)));
  localparam logic signed [2*W-1:0] RND_C = (2*W)'(1) << (DEC_WIDTH - 1);
  logic signed [2*W-1:0] px, py;
  logic signed [W-1:0] cx, cy;
  always_comb begin
    px = (2*W)'(x_out) * (2*W)'(CK);
    py = (2*W)'(y_out) * (2*W)'(CK);
    cx = W'((px + RND_C) >>> DEC_WIDTH);
    cy = W'((py + RND_C) >>> DEC_WIDTH);
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_mode <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_out <= x_in;
          y_out <= y_in;
          z_out <= z_in;
          out_mode <= in_mode;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          x_out <= nx;
          y_out <= ny;
          z_out <= nz;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= COMP;
`else
            state <= DONE;
            out_valid <= 1'b1;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x_out <= cx;
          y_out <= cy;
          out_valid <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: random and directed transactions checked against a plain-arithmetic CORDIC model.
module tb_cordic_iter_engine;
  localparam int ITER = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
  localparam int XUNIT = 16384;
  localparam int VEC_X = 11585;
`else
  localparam int LAT = ITER;
  localparam int XUNIT = 9949;
  localparam int VEC_X = 19078;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_mode = 0, out_ready = 0;
  logic in_ready, out_valid, out_mode;
  logic signed [15:0] x_in = 0, y_in = 0, z_in = 0, x_out, y_out, z_out;
  int checks = 0, errors = 0;
  int atab [16];
  int rx, ry, rz;

  cordic_iter_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .x_out(x_out), .y_out(y_out), .z_out(z_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic void model(input bit m, input int xi, input int yi, input int zi,
                                output int xo, output int yo, output int zo);
    logic signed [15:0] x, y, z, t;
    bit d;
    x = 16'(xi);
    y = 16'(yi);
    z = 16'(zi);
    for (int i = 0; i < ITER; i++) begin
      d = m ? (y < 0) : (z >= 0);
      t = x;
      x = d ? x - (y >>> i) : x + (y >>> i);
      y = d ? y + (t >>> i) : y - (t >>> i);
      z = d ? z - 16'(atab[i]) : z + 16'(atab[i]);
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = 16'((int'(x) * 9949 + 8192) >>> 14);
    y = 16'((int'(y) * 9949 + 8192) >>> 14);
`endif
    xo = int'(x);
    yo = int'(y);
    zo = int'(z);
  endfunction

  task automatic txn(input bit m, input int xi, input int yi, input int zi, input int hold,
                     output int xo, output int yo, output int zo);
    int n, bad, chg, ex, ey, ez;
    @(negedge clk);
    in_valid = 1; in_mode = m; x_in = 16'(xi); y_in = 16'(yi); z_in = 16'(zi);
    @(posedge clk); #1;
    n = 0;
    bad = 0;
    while (!out_valid && n < 200) begin
      bad += int'(in_ready);
      in_valid = 1'($urandom_range(0, 1));
      in_mode = 1'($urandom_range(0, 1));
      x_in = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, LAT);
    chk("in_ready_run", bad, 0);
    chk("in_ready_done", int'(in_ready), 0);
    chk("out_mode", int'(out_mode), int'(m));
    xo = int'(x_out); yo = int'(y_out); zo = int'(z_out);
    chg = 0;
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chg += int'(x_out != 16'(xo)) + int'(y_out != 16'(yo)) + int'(z_out != 16'(zo))
           + int'(!out_valid) + int'(in_ready);
    end
    if (hold > 0) chk("hold_stable", chg, 0);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);
    model(m, xi, yi, zi, ex, ey, ez);
    chk("x_exact", xo, ex);
    chk("y_exact", yo, ey);
    chk("z_exact", zo, ez);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) atab[i] = int'($floor($atan(2.0 ** (-i)) * 16384.0 + 0.5));
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_z", int'(z_out), 0);
    chk("rst_mode", int'(out_mode), 0);
    rst = 0;

    txn(0, XUNIT, 0, 8579, 10, rx, ry, rz);
    chk("rot_pos_x", rx, 14189, 4);
    chk("rot_pos_y", ry, 8192, 4);
    chk("rot_pos_z", rz, 0, 2);
    txn(0, XUNIT, 0, -8579, 2, rx, ry, rz);
    chk("rot_neg_x", rx, 14189, 4);
    chk("rot_neg_y", ry, -8192, 4);
    txn(1, 8192, 8192, 0, 0, rx, ry, rz);
    chk("vec_z", rz, 12868, 4);
    chk("vec_y", ry, 0, 2);
    chk("vec_x", rx, VEC_X, 4);

    // abort a transaction at iteration 5 with an asynchronous reset
    @(negedge clk);
    in_valid = 1; in_mode = 0; x_in = 16'(XUNIT); y_in = 0; z_in = 16'(8579);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_x", int'(x_out), 0);
    chk("mid_rst_y", int'(y_out), 0);
    chk("mid_rst_z", int'(z_out), 0);
    @(negedge clk);
    rst = 0;
    txn(0, XUNIT, 0, 8579, 0, rx, ry, rz);
    chk("post_rst_x", rx, 14189, 4);

    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0)
        txn(0, $urandom_range(0, 18000) - 9000, $urandom_range(0, 18000) - 9000,
            $urandom_range(0, 50000) - 25000, $urandom_range(0, 3), rx, ry, rz);
      else
        txn(1, $urandom_range(1, 11000), $urandom_range(0, 22000) - 11000,
            $urandom_range(0, 4000) - 2000, $urandom_range(0, 3), rx, ry, rz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
